// File: rtl/sort_pkg.sv
// sort_pkg: shared defaults and the tag-width helper for the sorting network.
package sort_pkg;
    localparam int SORT_WIDTH_DEF  = 10;
    localparam int SORT_INPUTS_DEF = 3;
    function automatic int sort_idx_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/sort_cas.sv
// sort_cas: combinational compare-exchange, larger value to hi, equal values keep their order.
// Ports: a/b in, hi/lo out; with SORT_NET_INDEX_EN, a_tag/b_tag follow their values to hi_tag/lo_tag.
module sort_cas #(
    parameter int WIDTH = 10,
    parameter int TAG_W = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SORT_NET_INDEX_EN
    input  logic [TAG_W-1:0] a_tag,
    input  logic [TAG_W-1:0] b_tag,
    output logic [TAG_W-1:0] hi_tag,
    output logic [TAG_W-1:0] lo_tag,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH:0] diff;
    logic           swap;
    // a - b borrows exactly when b > a, so the borrow bit is the swap decision
    assign diff = {1'b0, a} - {1'b0, b};
    assign swap = 1'(diff >> WIDTH);
    assign hi   = swap ? b : a;
    assign lo   = swap ? a : b;
`ifdef SORT_NET_INDEX_EN
    assign hi_tag = swap ? b_tag : a_tag;
    assign lo_tag = swap ? a_tag : b_tag;
`endif
endmodule

// File: rtl/sort_net_pipe.sv
// sort_net_pipe: pipelined odd-even transposition sorter, descending, lane 0 = maximum.
// Ports: clk, rst (async active-high), in_valid/in_ready/in_data, out_valid/out_ready/out_data.
// Macro SORT_NET_INDEX_EN adds out_idx: original input lane of each output slot.
module sort_net_pipe
    import sort_pkg::*;
#(
    parameter int WIDTH      = SORT_WIDTH_DEF,
    parameter int NUM_INPUTS = SORT_INPUTS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef SORT_NET_INDEX_EN
    output logic [NUM_INPUTS*sort_idx_w(NUM_INPUTS)-1:0] out_idx,
`endif
    output logic [NUM_INPUTS*WIDTH-1:0]   out_data
);
    localparam int IDX_W = sort_idx_w(NUM_INPUTS);

    logic [WIDTH-1:0]      src [NUM_INPUTS][NUM_INPUTS];
    logic [WIDTH-1:0]      d   [NUM_INPUTS][NUM_INPUTS];
    logic [WIDTH-1:0]      q   [NUM_INPUTS][NUM_INPUTS];
    logic [NUM_INPUTS-1:0] vld;
    logic                  advance;
`ifdef SORT_NET_INDEX_EN
    logic [IDX_W-1:0]      tsrc [NUM_INPUTS][NUM_INPUTS];
    logic [IDX_W-1:0]      td   [NUM_INPUTS][NUM_INPUTS];
    logic [IDX_W-1:0]      tq   [NUM_INPUTS][NUM_INPUTS];
`endif

    // the whole pipe moves as one unit whenever the output slot is free or being taken
    assign advance   = !vld[NUM_INPUTS-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[NUM_INPUTS-1];

    genvar s, i;
    for (s = 0; s < NUM_INPUTS; s++) begin : g_stage
        localparam int P = s % 2;
        for (i = 0; i < NUM_INPUTS; i++) begin : g_lane
            if (s == 0) begin : g_src_in
                assign src[s][i] = in_data[i*WIDTH +: WIDTH];
`ifdef SORT_NET_INDEX_EN
                assign tsrc[s][i] = IDX_W'(i);
`endif
            end else begin : g_src_q
                assign src[s][i] = q[s-1][i];
`ifdef SORT_NET_INDEX_EN
                assign tsrc[s][i] = tq[s-1][i];
`endif
            end
            // lane i opens a pair on this stage's parity; edge lanes without a partner pass through
            if (i >= P && (i - P) % 2 == 0 && i + 1 < NUM_INPUTS) begin : g_cas
                sort_cas #(.WIDTH(WIDTH), .TAG_W(IDX_W)) u_cas (
                    .a      (src[s][i]),
                    .b      (src[s][i+1]),
`ifdef SORT_NET_INDEX_EN
                    .a_tag  (tsrc[s][i]),
                    .b_tag  (tsrc[s][i+1]),
                    .hi_tag (td[s][i]),
                    .lo_tag (td[s][i+1]),
`endif
                    .hi     (d[s][i]),
                    .lo     (d[s][i+1])
                );
            end else if (!(i > P && (i - 1 - P) % 2 == 0)) begin : g_pass
                assign d[s][i] = src[s][i];
`ifdef SORT_NET_INDEX_EN
                assign td[s][i] = tsrc[s][i];
`endif
            end
        end
    end

    for (i = 0; i < NUM_INPUTS; i++) begin : g_out
        assign out_data[i*WIDTH +: WIDTH] = q[NUM_INPUTS-1][i];
`ifdef SORT_NET_INDEX_EN
        assign out_idx[i*IDX_W +: IDX_W] = tq[NUM_INPUTS-1][i];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int a = 0; a < NUM_INPUTS; a++)
                for (int b = 0; b < NUM_INPUTS; b++)
                    q[a][b] <= '0;
        end else if (advance) begin
            vld <= {vld[NUM_INPUTS-2:0], in_valid};
            for (int a = 0; a < NUM_INPUTS; a++)
                for (int b = 0; b < NUM_INPUTS; b++)
                    q[a][b] <= d[a][b];
        end
    end

`ifdef SORT_NET_INDEX_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < NUM_INPUTS; a++)
                for (int b = 0; b < NUM_INPUTS; b++)
                    tq[a][b] <= '0;
        end else if (advance) begin
            for (int a = 0; a < NUM_INPUTS; a++)
                for (int b = 0; b < NUM_INPUTS; b++)
                    tq[a][b] <= td[a][b];
        end
    end
`endif
endmodule

// File: tb/tb_sort_net_pipe.sv
// tb_sort_net_pipe: scoreboard bench for the default 3x10 sorter and an 8x16 instance.
module tb_sort_net_pipe;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [29:0]  in_data, out_data;
    logic         in8_valid, in8_ready, out8_valid, out8_ready;
    logic [127:0] in8_data, out8_data;
`ifdef SORT_NET_INDEX_EN
    logic [5:0]   out_idx;
    logic [23:0]  out8_idx;
`endif

    sort_net_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef SORT_NET_INDEX_EN
        .out_idx(out_idx),
`endif
        .out_data(out_data)
    );

    sort_net_pipe #(.WIDTH(16), .NUM_INPUTS(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data),
        .out_valid(out8_valid), .out_ready(out8_ready),
`ifdef SORT_NET_INDEX_EN
        .out_idx(out8_idx),
`endif
        .out_data(out8_data)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int acc8   = 0;
    logic [127:0] q3[$];
    logic [127:0] q8[$];

    function automatic logic [127:0] sort_ref(input logic [127:0] v, input int w, input int n);
        logic [15:0]  lane [8];
        logic [15:0]  t;
        logic [127:0] r = '0;
        for (int k = 0; k < n; k++) lane[k] = 16'((v >> (k * w)) & ((128'd1 << w) - 128'd1));
        for (int k = 0; k < n; k++)
            for (int j = k + 1; j < n; j++)
                if (lane[j] > lane[k]) begin
                    t = lane[k];
                    lane[k] = lane[j];
                    lane[j] = t;
                end
        for (int k = 0; k < n; k++) r = r | (128'(lane[k]) << (k * w));
        return r;
    endfunction

    function automatic logic [29:0] pack3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        return {c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // samples handshakes mid-cycle, scores outputs, then records accepted inputs
    task automatic tick();
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("out3_expected", 128'(q3.size() != 0), 128'(1));
            if (q3.size() != 0) chk("out3_data", 128'(out_data), q3.pop_front());
        end
        if (out8_valid && out8_ready) begin
            chk("out8_expected", 128'(q8.size() != 0), 128'(1));
            if (q8.size() != 0) chk("out8_data", out8_data, q8.pop_front());
        end
        if (in_valid && in_ready) q3.push_back(sort_ref(128'(in_data), 10, 3));
        if (in8_valid && in8_ready) begin
            q8.push_back(sort_ref(in8_data, 16, 8));
            acc8++;
        end
        @(posedge clk);
        #1;
    endtask

    logic [29:0]  bp [5];
    logic [29:0]  held;
    logic [127:0] v8;
    int           budget;

    initial begin
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in8_valid = 1'b0; in8_data = '0; out8_ready = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_out_valid", 128'(out_valid), 128'(0));
        chk("post_rst_out_data", 128'(out_data), 128'(0));
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        chk("post_rst_out8_data", out8_data, 128'(0));

        // basic sort and latency
        in_data = pack3(10'd3, 10'd9, 10'd5); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat3_c1", 128'(out_valid), 128'(0));
        tick();
        chk("lat3_c2", 128'(out_valid), 128'(0));
        tick();
        chk("lat3_c3", 128'(out_valid), 128'(1));
        chk("basic_data", 128'(out_data), 128'(pack3(10'd9, 10'd5, 10'd3)));
        tick();

        // ties and extremes
        in_data = pack3(10'd1023, 10'd0, 10'd1023); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("ties_valid", 128'(out_valid), 128'(1));
        chk("ties_data", 128'(out_data), 128'(pack3(10'd1023, 10'd1023, 10'd0)));
`ifdef SORT_NET_INDEX_EN
        chk("ties_idx", 128'(out_idx), 128'({2'd1, 2'd2, 2'd0}));
`endif
        tick();

        // back-pressure: five back-to-back, output held for four cycles
        bp[0] = pack3(10'd10, 10'd20, 10'd30);
        bp[1] = pack3(10'd1023, 10'd1, 10'd512);
        bp[2] = pack3(10'd7, 10'd7, 10'd7);
        bp[3] = pack3(10'd0, 10'd5, 10'd0);
        bp[4] = pack3(10'd100, 10'd300, 10'd200);
        for (int k = 0; k < 5; k++) begin
            in_data = bp[k]; in_valid = 1'b1;
            if (k == 3) begin
                chk("bp_first_valid", 128'(out_valid), 128'(1));
                out_ready = 1'b0;
                held = out_data;
                for (int h = 0; h < 4; h++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 128'(in_ready), 128'(0));
                    chk("bp_hold_valid", 128'(out_valid), 128'(1));
                    chk("bp_hold_data", 128'(out_data), 128'(held));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        budget = 20;
        while (q3.size() != 0 && budget > 0) begin tick(); budget--; end
        chk("bp_drained", 128'(q3.size()), 128'(0));

        // reset with two vectors in flight
        in_data = pack3(10'd11, 10'd22, 10'd33); in_valid = 1'b1; tick();
        in_data = pack3(10'd44, 10'd55, 10'd66); tick();
        in_valid = 1'b0; out_ready = 1'b0; tick();
        chk("mid_pre_valid", 128'(out_valid), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        q3.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        chk("mid_rel_in_ready", 128'(in_ready), 128'(1));
        for (int k = 0; k < 6; k++) tick();
        chk("mid_no_ghost", 128'(out_valid), 128'(0));

        // 8-lane latency
        in8_data = 128'h0001_ffff_0000_1234_8000_7fff_00ff_1234; in8_valid = 1'b1;
        v8 = sort_ref(in8_data, 16, 8);
        tick();
        in8_valid = 1'b0;
        for (int e = 1; e < 8; e++) begin
            chk("lat8_idle", 128'(out8_valid), 128'(0));
            tick();
        end
        chk("lat8_valid", 128'(out8_valid), 128'(1));
        chk("lat8_data", out8_data, v8);
        tick();

        // 8-lane random stream with random back-pressure
        acc8 = 0;
        budget = 20000;
        while (acc8 < 1000 && budget > 0) begin
            if (!(in8_valid && !in8_ready)) begin
                in8_data = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 7) == 0)
                    for (int k = 0; k < 8; k++) in8_data[k*16 +: 16] = $urandom_range(0, 1) != 0 ? 16'hffff : 16'h0000;
                in8_valid = $urandom_range(0, 3) != 0;
            end
            out8_ready = $urandom_range(0, 3) != 0;
            tick();
            budget--;
        end
        chk("rand8_accepted", 128'(acc8), 128'(1000));
        in8_valid = 1'b0; out8_ready = 1'b1;
        budget = 50;
        while (q8.size() != 0 && budget > 0) begin tick(); budget--; end
        chk("rand8_drained", 128'(q8.size()), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
